// File: rtl/ram_scan_reader_pkg.sv
// rtl/ram_scan_reader_pkg.sv - scan reader FSM encoding and shared 7-segment glyph table
package ram_scan_reader_pkg;

    localparam logic [1:0] ST_WAIT_TICK = 2'd0;
    localparam logic [1:0] ST_READ      = 2'd1;
    localparam logic [1:0] ST_CAPTURE   = 2'd2;

    // Active-low {g,f,e,d,c,b,a}, listed F down to 0 so entry N sits at index N.
    localparam logic [15:0][6:0] SEG7_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble);
        return SEG7_TABLE[nibble];
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - 4-bit value to active-low 7-segment glyph
module hex_to_seg7
    import ram_scan_reader_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = seg7_glyph(nibble);

endmodule

// File: rtl/ram_scan_reader.sv
// rtl/ram_scan_reader.sv - steps through a synchronous-read RAM and shows address/data on hex displays
module ram_scan_reader
    import ram_scan_reader_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 4,
    parameter int TICK_DIV   = 50_000_000,
    parameter int RD_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              STEP,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [DATA_W-1:0] RD_DATA,
    output logic [ADDR_W-1:0] CUR_ADDR,
    output logic [DATA_W-1:0] CUR_DATA,
    output logic              DATA_VALID,
    output logic [6:0]        HEX_ADDR0,
    output logic [6:0]        HEX_ADDR1,
    output logic [6:0]        HEX_DATA
);

    localparam int          CNT_W    = $clog2(TICK_DIV);
    localparam logic [1:0]  LAT_LAST = 2'(RD_LATENCY - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0] cur_data_q, cur_data_d;
    logic              data_valid_q, data_valid_d;
    logic              tick;
    logic              trigger;

    assign tick    = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign trigger = (EN & tick) | (~EN & STEP);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_cnt_d    = lat_cnt_q;
        rd_addr_d    = rd_addr_q;
        cur_addr_d   = cur_addr_q;
        cur_data_d   = cur_data_q;
        data_valid_d = 1'b0;
        case (state_q)
            ST_WAIT_TICK: begin
                if (EN) begin
                    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                end
                if (trigger) begin
                    state_d   = ST_READ;
                    lat_cnt_d = 2'd0;
                end
            end
            ST_READ: begin
                // Data is sampled on leaving READ so CUR_*/DATA_VALID appear together in CAPTURE.
                lat_cnt_d = lat_cnt_q + 2'd1;
                if (lat_cnt_q == LAT_LAST) begin
                    state_d      = ST_CAPTURE;
                    cur_data_d   = RD_DATA;
                    cur_addr_d   = rd_addr_q;
                    data_valid_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                rd_addr_d = rd_addr_q + ADDR_W'(1);
                state_d   = ST_WAIT_TICK;
            end
            default: state_d = ST_WAIT_TICK;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_WAIT_TICK;
            cnt_q        <= '0;
            lat_cnt_q    <= 2'd0;
            rd_addr_q    <= '0;
            cur_addr_q   <= '0;
            cur_data_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            rd_addr_q    <= rd_addr_d;
            cur_addr_q   <= cur_addr_d;
            cur_data_q   <= cur_data_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign RD_ADDR    = rd_addr_q;
    assign CUR_ADDR   = cur_addr_q;
    assign CUR_DATA   = cur_data_q;
    assign DATA_VALID = data_valid_q;

    hex_to_seg7 u_hex_addr0 (.nibble(4'(cur_addr_q)),      .seg(HEX_ADDR0));
    hex_to_seg7 u_hex_addr1 (.nibble(4'(cur_addr_q >> 4)), .seg(HEX_ADDR1));
    hex_to_seg7 u_hex_data  (.nibble(4'(cur_data_q)),      .seg(HEX_DATA));

endmodule

// File: tb/tb_ram_scan_reader.sv
// tb/tb_ram_scan_reader.sv - directed scoreboard bench for ram_scan_reader at read latencies 1 and 3
module tb_ram_scan_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, step, dv;
    logic [4:0] rd_addr, cur_addr;
    logic [3:0] rd_data, cur_data;
    logic [6:0] hex_a0, hex_a1, hex_d;

    logic       rst3, en3, step3, dv3;
    logic [4:0] rd_addr3, cur_addr3;
    logic [3:0] rd_data3, cur_data3;
    logic [6:0] hex3_a0, hex3_a1, hex3_d;

    int checks = 0;
    int errors = 0;

    logic [8:0] q1[$];
    logic [8:0] q3[$];

    ram_scan_reader #(.ADDR_W(5), .DATA_W(4), .TICK_DIV(4), .RD_LATENCY(1)) dut (
        .CLK(clk), .RST(rst), .EN(en), .STEP(step),
        .RD_ADDR(rd_addr), .RD_DATA(rd_data),
        .CUR_ADDR(cur_addr), .CUR_DATA(cur_data), .DATA_VALID(dv),
        .HEX_ADDR0(hex_a0), .HEX_ADDR1(hex_a1), .HEX_DATA(hex_d)
    );

    ram_scan_reader #(.ADDR_W(5), .DATA_W(4), .TICK_DIV(4), .RD_LATENCY(3)) dut3 (
        .CLK(clk), .RST(rst3), .EN(en3), .STEP(step3),
        .RD_ADDR(rd_addr3), .RD_DATA(rd_data3),
        .CUR_ADDR(cur_addr3), .CUR_DATA(cur_data3), .DATA_VALID(dv3),
        .HEX_ADDR0(hex3_a0), .HEX_ADDR1(hex3_a1), .HEX_DATA(hex3_d)
    );

    logic [3:0] mem [32];
    logic [3:0] p1, p2;
    initial for (int i = 0; i < 32; i++) mem[i] = 4'(i) ^ 4'hA;
    always @(posedge clk) rd_data <= mem[rd_addr];
    always @(posedge clk) begin
        p1       <= mem[rd_addr3];
        p2       <= p1;
        rd_data3 <= p2;
    end

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;  4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
        endcase
    endfunction

    function automatic logic [8:0] item(input int a);
        logic [4:0] ad;
        ad = 5'(a);
        return {ad, 4'(ad) ^ 4'hA};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_dv(input int which, input int limit, output int n);
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            if (which == 1) begin step = 1'b0; seen = dv; end
            else begin step3 = 1'b0; seen = dv3; end
        end
        if (!seen) n = -1;
    endtask

    // Scoreboard pop and RD_ADDR movement monitor, one per instance.
    logic       rst_edge1, rst_edge3, prev_dv1, prev_dv3;
    logic [4:0] prev_a1, prev_a3;
    logic [8:0] e1, e3;
    always @(posedge clk) begin
        rst_edge1 <= rst;
        rst_edge3 <= rst3;
    end

    always @(negedge clk) begin
        if (rd_addr !== prev_a1) begin
            check("l1_rd_addr_move_allowed", {31'd0, prev_dv1 | rst_edge1}, 32'd1);
            check("l1_rd_addr_value", rd_addr, rst_edge1 ? 5'd0 : 5'(prev_a1 + 5'd1));
        end
        if (dv) begin
            check("l1_sb_nonempty", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                check("l1_cur_addr", cur_addr, e1[8:4]);
                check("l1_cur_data", cur_data, e1[3:0]);
                check("l1_hex_data", hex_d, glyph(e1[3:0]));
                check("l1_hex_addr0", hex_a0, glyph(e1[7:4]));
                check("l1_hex_addr1", hex_a1, glyph({3'b000, e1[8]}));
            end
        end
        prev_a1  <= rd_addr;
        prev_dv1 <= dv;
    end

    always @(negedge clk) begin
        if (rd_addr3 !== prev_a3) begin
            check("l3_rd_addr_move_allowed", {31'd0, prev_dv3 | rst_edge3}, 32'd1);
            check("l3_rd_addr_value", rd_addr3, rst_edge3 ? 5'd0 : 5'(prev_a3 + 5'd1));
        end
        if (dv3) begin
            check("l3_sb_nonempty", q3.size() != 0, 1);
            if (q3.size() != 0) begin
                e3 = q3.pop_front();
                check("l3_cur_addr", cur_addr3, e3[8:4]);
                check("l3_cur_data", cur_data3, e3[3:0]);
                check("l3_hex_data", hex3_d, glyph(e3[3:0]));
            end
        end
        prev_a3  <= rd_addr3;
        prev_dv3 <= dv3;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int cnt;
        rst = 1'b1; en = 1'b0; step = 1'b0;
        rst3 = 1'b1; en3 = 1'b0; step3 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_cur_addr", cur_addr, 0);
        check("reset_cur_data", cur_data, 0);
        check("reset_dv", dv, 0);
        check("reset_rd_addr", rd_addr, 0);
        check("reset_hex_data", hex_d, 7'b1000000);

        q1.push_back(item(0));
        q1.push_back(item(1));
        rst = 1'b0; en = 1'b1;
        wait_dv(1, 20, n); check("auto_first_latency", n, 5);
        wait_dv(1, 20, n); check("auto_period", n, 6);
        for (int i = 2; i <= 32; i++) begin
            q1.push_back(item(i));
            wait_dv(1, 20, n); check("wrap_period", n, 6);
            if (i == 31) begin
                check("wrap_addr31", cur_addr, 31);
                check("wrap_hex_addr1", hex_a1, 7'b1111001);
                check("wrap_hex_addr0", hex_a0, 7'b0001110);
            end
        end
        check("wrap_to_zero", cur_addr, 0);

        en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dv) cnt++;
        end
        check("paused_no_dv", cnt, 0);
        q1.push_back(item(1));
        step = 1'b1;
        wait_dv(1, 10, n); check("step_latency", n, 2);
        @(negedge clk);
        q1.push_back(item(2));
        step = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 1) step = 1'b0;
            if (dv) cnt++;
        end
        check("held_step_one_capture", cnt, 1);

        step = 1'b1;
        @(negedge clk);
        step = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rd_addr", rd_addr, 0);
        check("abort_no_dv", dv, 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dv) cnt++;
        end
        check("abort_quiet", cnt, 0);
        q1.push_back(item(0));
        step = 1'b1;
        wait_dv(1, 10, n); check("restart_latency", n, 2);

        rst3 = 1'b0;
        @(negedge clk);
        q3.push_back(item(0));
        step3 = 1'b1;
        wait_dv(3, 10, n); check("lat3_step_latency", n, 4);
        @(negedge clk);
        q3.push_back(item(1));
        step3 = 1'b1;
        wait_dv(3, 10, n); check("lat3_step2_latency", n, 4);
        @(negedge clk);
        q3.push_back(item(2));
        en3 = 1'b1;
        wait_dv(3, 20, n); check("lat3_auto_latency", n, 7);
        en3 = 1'b0;
        repeat (10) @(negedge clk);

        check("l1_sb_drained", q1.size(), 0);
        check("l3_sb_drained", q3.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
